mem_bus_fabric: RTL and testbench

Parametrised memory-bus interconnect between the picorv32 native memory interface and up to NUM_SLAVES targets. It performs base/mask address decoding, per-slave select generation, read-data return and ready merging. Unlike the fixed decode in the SoC top, it also tracks each transaction with a state machine. Unmapped accesses and stalled slaves are terminated with an error response, so the core can never hang.

---
 rtl/bus_pkg.sv | 17 +
 rtl/mem_bus_fabric_if.sv | 14 +
 rtl/mem_bus_fabric_addr_decode.sv | 34 +++
 rtl/mem_bus_fabric.sv | 166 ++++++++++++++++
 tb/tb_mem_bus_fabric.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus fabric: FSM encoding, error codes
// and the default read data returned on an error termination.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      TURN   = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_UNMAPPED = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_fabric_if.sv
// Core-side native memory bus (picorv32 style valid/ready handshake).
// The core drives through the master modport, the fabric sits on slave.
interface mem_bus_fabric_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (output mem_valid, output mem_addr,
                   input  mem_rdata, input  mem_ready);

   modport slave  (input  mem_valid, input  mem_addr,
                   output mem_rdata, output mem_ready);
endinterface

// File: rtl/mem_bus_fabric_addr_decode.sv
// Combinational base/mask address decoder. Overlapping windows resolve to
// the lowest slave index.
module addr_decode #(
   parameter int                       NUM_SLAVES = 5,
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {NUM_SLAVES{32'h0}},
   parameter int                       IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic [31:0]      addr,
   output logic             hit_any,
   output logic [IDX_W-1:0] idx
);

   logic [NUM_SLAVES-1:0] hit;

   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
         assign hit[gi] = (addr & SLAVE_MASK[gi*32 +: 32]) == SLAVE_BASE[gi*32 +: 32];
      end
   endgenerate

   assign hit_any = |hit;

   // Priority encode: scan downwards so the lowest hitting index is kept last.
   always_comb begin
      idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mem_bus_fabric.sv
// Memory-bus interconnect: decodes the core address onto one of NUM_SLAVES
// targets, tracks each transaction with a small FSM and terminates unmapped
// or stalled accesses with an error response so the core never hangs.
module mem_bus_fabric
   import bus_pkg::*;
#(
   parameter int                       NUM_SLAVES     = 5,
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'h0}},
   parameter int                       TIMEOUT_CYCLES = 255,
   parameter logic [31:0]              ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                     clk,
   input  logic                     reset_n,
   mem_bus_fabric_if.slave          bus,
   output logic [NUM_SLAVES-1:0]    slv_sel,
   input  logic [NUM_SLAVES-1:0]    slv_ready,
   input  logic [NUM_SLAVES*32-1:0] slv_rdata,
   output logic                     bus_err,
   output logic [1:0]               err_code,
   output logic [31:0]              err_addr,
   output logic [15:0]              err_count
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  cur_reg, cur_next;
   logic [15:0]       timer_reg, timer_next;
   logic [1:0]        err_code_reg;
   logic [31:0]       err_addr_reg;
   logic [15:0]       err_count_reg;

   logic              dec_hit;
   logic [IDX_W-1:0]  dec_idx;
   logic [31:0]       slot_rdata [NUM_SLAVES];

   logic [NUM_SLAVES-1:0] sel_c;
   logic                  ready_c;
   logic [31:0]           rdata_c;
   logic                  err_c;
   logic [1:0]            err_kind_c;

   addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK),
      .IDX_W      (IDX_W)
   ) u_decode (
      .addr    (bus.mem_addr),
      .hit_any (dec_hit),
      .idx     (dec_idx)
   );

   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
         assign slot_rdata[gi] = slv_rdata[gi*32 +: 32];
      end
   endgenerate

   // Next-state, select, response and error-event logic for the transaction FSM.
   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      timer_next = timer_reg;
      sel_c      = '0;
      ready_c    = 1'b0;
      rdata_c    = 32'h0;
      err_c      = 1'b0;
      err_kind_c = ERR_NONE;

      case (state_reg)
         IDLE: begin
            if (bus.mem_valid) begin
               if (dec_hit) begin
                  sel_c[dec_idx] = 1'b1;
                  cur_next       = dec_idx;
                  timer_next     = 16'd1;
                  if (slv_ready[dec_idx]) begin
                     ready_c    = 1'b1;
                     rdata_c    = slot_rdata[dec_idx];
                     state_next = TURN;
                  end else begin
                     state_next = ACTIVE;
                  end
               end else begin
                  ready_c    = 1'b1;
                  rdata_c    = ERR_RDATA;
                  err_c      = 1'b1;
                  err_kind_c = ERR_UNMAPPED;
                  state_next = TURN;
               end
            end
         end

         ACTIVE: begin
            if (!bus.mem_valid) begin
               // Core withdrew the request: drop it silently.
               state_next = IDLE;
            end else if (slv_ready[cur_reg]) begin
               sel_c[cur_reg] = 1'b1;
               ready_c        = 1'b1;
               rdata_c        = slot_rdata[cur_reg];
               state_next     = TURN;
            end else if (timer_reg == 16'(TIMEOUT_CYCLES)) begin
               ready_c    = 1'b1;
               rdata_c    = ERR_RDATA;
               err_c      = 1'b1;
               err_kind_c = ERR_TIMEOUT;
               state_next = TURN;
            end else begin
               sel_c[cur_reg] = 1'b1;
               timer_next     = timer_reg + 16'd1;
            end
         end

         TURN: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Outputs are held quiet for as long as reset is applied.
      if (!reset_n) begin
         sel_c   = '0;
         ready_c = 1'b0;
         rdata_c = 32'h0;
         err_c   = 1'b0;
      end
   end

   // State, timer and error registers; error state only changes on an error termination.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cur_reg       <= '0;
         timer_reg     <= 16'd0;
         err_code_reg  <= ERR_NONE;
         err_addr_reg  <= 32'h0;
         err_count_reg <= 16'd0;
      end else begin
         state_reg <= state_next;
         cur_reg   <= cur_next;
         timer_reg <= timer_next;
         if (err_c) begin
            err_code_reg <= err_kind_c;
            err_addr_reg <= bus.mem_addr;
            if (err_count_reg != 16'hFFFF) begin
               err_count_reg <= err_count_reg + 16'd1;
            end
         end
      end
   end

   assign slv_sel       = sel_c;
   assign bus.mem_ready = ready_c;
   assign bus.mem_rdata = rdata_c;
   assign bus_err       = err_c;
   assign err_code      = err_code_reg;
   assign err_addr      = err_addr_reg;
   assign err_count     = err_count_reg;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Bench for mem_bus_fabric: a driver issues directed and random transactions
// and queues the expected response; a monitor checks each response as it
// appears on the bus.
module tb_mem_bus_fabric;

   localparam int NS = 5;
   localparam int T  = 4;
   localparam logic [NS*32-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h8000_0008,
                                        32'h2000_0000, 32'h0000_0000};
   localparam logic [NS*32-1:0] MASK = {32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_FFF8,
                                        32'hF000_0000, 32'hFFFE_0000};

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NS-1:0]    slv_sel;
   logic [NS-1:0]    slv_ready;
   logic [NS*32-1:0] slv_rdata;
   logic             bus_err;
   logic [1:0]       err_code;
   logic [31:0]      err_addr;
   logic [15:0]      err_count;

   mem_bus_fabric_if bus ();

   mem_bus_fabric #(
      .NUM_SLAVES     (NS),
      .SLAVE_BASE     (BASE),
      .SLAVE_MASK     (MASK),
      .TIMEOUT_CYCLES (T),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .slv_sel   (slv_sel),
      .slv_ready (slv_ready),
      .slv_rdata (slv_rdata),
      .bus_err   (bus_err),
      .err_code  (err_code),
      .err_addr  (err_addr),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          abort;
      logic [31:0]   addr;
      logic [31:0]   rdata;
      logic          err;
      int            lat;
      logic [NS-1:0] sel;
      logic [1:0]    code;
      logic [31:0]   eaddr;
      logic [15:0]   ecnt;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   mon_en     = 1'b0;

   logic [1:0]  m_code;
   logic [31:0] m_addr;
   logic [15:0] m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference decode: first window (lowest index) whose masked compare matches.
   function automatic int ref_decode(input logic [31:0] a);
      logic [NS*32-1:0] b = BASE;
      logic [NS*32-1:0] m = MASK;
      for (int i = 0; i < NS; i++) begin
         if ((a & m[i*32 +: 32]) == b[i*32 +: 32]) return i;
      end
      return -1;
   endfunction

   // One transaction; entered and left at posedge+1.
   task automatic do_txn(input logic [31:0] addr, input int lat, input bit distract,
                         input bit fix, input logic [31:0] fdata);
      exp_t        e;
      int          idx;
      int          dur;
      logic [31:0] data [NS];
      idx = ref_decode(addr);
      for (int i = 0; i < NS; i++) begin
         data[i]             = $urandom;
         slv_rdata[i*32 +: 32] = data[i];
      end
      if (fix && idx >= 0) begin
         data[idx]               = fdata;
         slv_rdata[idx*32 +: 32] = fdata;
      end
      e.abort = 1'b0;
      e.addr  = addr;
      if (idx < 0) begin
         dur = 0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b1; e.sel = '0;
         m_code = 2'b01; m_addr = addr; if (m_cnt != 16'hFFFF) m_cnt++;
      end else if (lat <= T) begin
         dur = lat; e.rdata = data[idx]; e.err = 1'b0; e.sel = NS'(1) << idx;
      end else begin
         dur = T; e.rdata = 32'hDEAD_BEEF; e.err = 1'b1; e.sel = '0;
         m_code = 2'b10; m_addr = addr; if (m_cnt != 16'hFFFF) m_cnt++;
      end
      e.lat = dur; e.code = m_code; e.eaddr = m_addr; e.ecnt = m_cnt;
      sb.push_back(e);
      $display("txn addr=%08h slave=%0d lat=%0d -> rdata=%08h err=%0b after %0d cycles",
               addr, idx, lat, e.rdata, e.err, dur);
      for (int c = 0; c <= dur; c++) begin
         bus.mem_valid = 1'b1;
         bus.mem_addr  = addr;
         slv_ready     = '0;
         if (idx >= 0 && c == lat) slv_ready[idx] = 1'b1;
         if (distract && idx >= 0 && c >= 1 && $urandom_range(0, 1) == 1)
            slv_ready[(idx + 1 + $urandom_range(0, NS - 2)) % NS] = 1'b1;
         @(posedge clk); #1;
      end
      bus.mem_valid = 1'b0;
      slv_ready     = '0;
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) begin
         @(posedge clk); #1;
      end
   endtask

   // Request that the core withdraws after a cycles, before any ready or timeout.
   task automatic do_abort(input logic [31:0] addr, input int a);
      exp_t e;
      e.abort = 1'b1; e.addr = addr; e.rdata = 32'h0; e.err = 1'b0; e.lat = 0;
      e.sel = '0; e.code = m_code; e.eaddr = m_addr; e.ecnt = m_cnt;
      sb.push_back(e);
      $display("txn addr=%08h aborted after %0d cycles -> no response", addr, a);
      slv_ready = '0;
      for (int c = 0; c < a; c++) begin
         bus.mem_valid = 1'b1;
         bus.mem_addr  = addr;
         @(posedge clk); #1;
      end
      bus.mem_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rand_txn();
      logic [31:0] a;
      int          cat;
      cat = $urandom_range(0, 6);
      case (cat)
         0: a = $urandom & 32'h0001_FFFF;
         1: a = {4'h2, 4'($urandom_range(1, 15)), 24'($urandom)};
         2: a = 32'h8000_0008 | ($urandom & 32'h7);
         3: a = {8'h20, 24'($urandom)};
         4: a = {16'h3000, 16'($urandom)};
         default: a = {4'h4, 28'($urandom)};
      endcase
      if (cat == 6)
         do_abort(32'h8000_0008, $urandom_range(1, T - 1));
      else
         do_txn(a, $urandom_range(0, T + 2), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
   endtask

   // Monitor: measure latency of each request and check every response it sees.
   initial begin
      exp_t e;
      exp_t cur_e;
      bit   prev_v    = 1'b0;
      bit   responded = 1'b0;
      bit   turn_chk  = 1'b0;
      int   cyc       = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev_v = 1'b0; responded = 1'b0; turn_chk = 1'b0;
         end else begin
            if (turn_chk) begin
               check("turn_ready", bus.mem_ready, 1'b0);
               check("turn_sel", slv_sel, '0);
               check("err_code", err_code, cur_e.code);
               check("err_addr", err_addr, cur_e.eaddr);
               check("err_count", err_count, cur_e.ecnt);
               turn_chk = 1'b0;
            end
            if (bus.mem_valid) begin
               if (!prev_v) begin
                  cyc = 0; responded = 1'b0;
               end else begin
                  cyc++;
               end
               if (bus.mem_ready && !responded) begin
                  responded = 1'b1;
                  if (sb.size() == 0) begin
                     check("spurious_ready", bus.mem_ready, 1'b0);
                  end else begin
                     e = sb.pop_front();
                     check("unexpected_ready", 1'b1, !e.abort);
                     check("latency", cyc, e.lat);
                     check("rdata", bus.mem_rdata, e.rdata);
                     check("bus_err", bus_err, e.err);
                     check("resp_sel", slv_sel, e.sel);
                     cur_e = e; turn_chk = 1'b1;
                  end
               end
            end else if (prev_v && !responded) begin
               if (sb.size() == 0) begin
                  check("orphan_request", 1'b0, 1'b1);
               end else begin
                  e = sb.pop_front();
                  check("response_seen", responded, !e.abort);
               end
            end
            prev_v = bus.mem_valid;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset_n       = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_addr  = 32'h0;
      slv_ready     = '0;
      slv_rdata     = '0;
      m_code = 2'b00; m_addr = 32'h0; m_cnt = 16'h0;

      // Reset state.
      @(posedge clk); #1;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 32'h4000_0000;
      @(negedge clk);
      check("rst_ready", bus.mem_ready, 1'b0);
      check("rst_err", bus_err, 1'b0);
      check("rst_rdata", bus.mem_rdata, 32'h0);
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_err_code", err_code, 2'b00);
      check("rst_err_addr", err_addr, 32'h0);
      check("rst_err_count", err_count, 16'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Directed cases.
      do_txn(32'h0000_0100, 0, 1'b0, 1'b1, 32'h1234_5678);
      do_txn(32'h8000_0008, 3, 1'b0, 1'b0, 32'h0);
      do_txn(32'h4000_0000, 0, 1'b0, 1'b0, 32'h0);
      do_txn(32'h8000_000C, 99, 1'b1, 1'b0, 32'h0);
      do_txn(32'h2000_1000, 1, 1'b0, 1'b0, 32'h0);
      do_txn(32'h3000_0010, T, 1'b1, 1'b0, 32'h0);
      do_txn(32'h0000_0200, T + 1, 1'b0, 1'b0, 32'h0);
      do_abort(32'h8000_0008, 2);
      do_txn(32'h2000_0040, 2, 1'b1, 1'b0, 32'h0);

      for (int n = 0; n < 150; n++) rand_txn();
      do_txn(32'h4000_0004, 0, 1'b0, 1'b0, 32'h0);

      // Reset in the middle of an ACTIVE transaction.
      mon_en = 1'b0;
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 32'h8000_000C;
      slv_ready     = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_sel", slv_sel, '0);
      check("midrst_ready", bus.mem_ready, 1'b0);
      check("midrst_err", bus_err, 1'b0);
      check("midrst_rdata", bus.mem_rdata, 32'h0);
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      check("midrst_err_code", err_code, 2'b00);
      check("midrst_err_addr", err_addr, 32'h0);
      check("midrst_err_count", err_count, 16'h0);
      m_code = 2'b00; m_addr = 32'h0; m_cnt = 16'h0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      do_txn(32'h0000_0300, 1, 1'b0, 1'b0, 32'h0);
      for (int n = 0; n < 20; n++) rand_txn();

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
